// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } md_state_e;

    localparam int          MD_LATENCY = 34;
    localparam logic [31:0] DIV0_QUOT  = 32'hFFFF_FFFF;

    function automatic logic op_signed_a(input md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_signed_b(input md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// Iteration datapath: radix-2 shift-add multiply and restoring divide on magnitudes.
module muldiv_core #(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   a_mag_i,
    input  logic [XLEN-1:0]   b_mag_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic [XLEN-1:0]   rem_o
);

    // Multiply: acc = {partial product, remaining multiplier bits}, op = multiplicand.
    // Divide:   acc low half = dividend shifting out / quotient shifting in, op = divisor.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   op_q, op_d;
    logic [XLEN:0]     add_sum;
    logic [XLEN:0]     shifted;
    logic [XLEN:0]     diff;
    logic              ge;

    always_comb begin
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op_q} : '0);
        shifted = {rem_q, acc_q[XLEN-1]};
        diff    = shifted - {1'b0, op_q};
        // The shifted remainder is always below 2*divisor, so the borrow bit alone decides.
        ge      = ~diff[XLEN];
        if (load_i) begin
            rem_d = '0;
            if (is_div_i) begin
                acc_d = {{XLEN{1'b0}}, a_mag_i};
                op_d  = b_mag_i;
            end else begin
                acc_d = {{XLEN{1'b0}}, b_mag_i};
                op_d  = a_mag_i;
            end
        end else if (step_i) begin
            if (is_div_i) begin
                rem_d = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ge};
            end else begin
                acc_d = {add_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            rem_q <= '0;
            op_q  <= '0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            op_q  <= op_d;
        end
    end

    assign acc_o = acc_q;
    assign rem_o = rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M unit: FSM, sign handling and special cases around muldiv_core.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [2:0]      func3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    md_op_e            op_q, op_d;
    logic [4:0]        rd_pend_q, rd_pend_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic [XLEN-1:0]   a_raw_q, a_raw_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              neg_q, neg_d;
    logic              sa_q, sa_d;
    logic              div0_q, div0_d;
    logic              ovf_q, ovf_d;

    md_op_e            op_in;
    logic              sa_in, sb_in;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              accept;
    logic              core_load, core_step, core_div;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, fix_res;

    assign op_in  = md_op_e'(func3_i);
    assign sa_in  = op_signed_a(op_in) && rs1_i[XLEN-1];
    assign sb_in  = op_signed_b(op_in) && rs2_i[XLEN-1];
    assign a_mag  = sa_in ? -rs1_i : rs1_i;
    assign b_mag  = sb_in ? -rs2_i : rs2_i;
    assign accept = (state_q == ST_IDLE) && valid_i && !flush_i;

    assign core_div = (state_q == ST_IDLE) ? func3_i[2] : op_q[2];

    muldiv_core #(.XLEN(XLEN)) u_core (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (core_load),
        .step_i   (core_step),
        .is_div_i (core_div),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .acc_o    (acc),
        .rem_o    (rem)
    );

    // Sign correction and result selection, registered in FIX.
    always_comb begin
        prod_s = neg_q ? -acc : acc;
        quot_s = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_s  = sa_q ? -rem : rem;
        case (op_q)
            MD_MUL:                       fix_res = prod_s[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fix_res = div0_q ? DIV0_QUOT : (ovf_q ? INT_MIN : quot_s);
            default:                      fix_res = div0_q ? a_raw_q : (ovf_q ? '0 : rem_s);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_pend_d = rd_pend_q;
        rd_out_d  = rd_out_q;
        a_raw_d   = a_raw_q;
        result_d  = result_q;
        neg_d     = neg_q;
        sa_d      = sa_q;
        div0_d    = div0_q;
        ovf_d     = ovf_q;
        core_load = 1'b0;
        core_step = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_CALC;
                    cnt_d     = '0;
                    op_d      = op_in;
                    rd_pend_d = rd_i;
                    a_raw_d   = rs1_i;
                    neg_d     = sa_in ^ sb_in;
                    sa_d      = sa_in;
                    div0_d    = (rs2_i == '0);
                    ovf_d     = op_signed_b(op_in) && func3_i[2] &&
                                (rs1_i == INT_MIN) && (rs2_i == '1);
                    core_load = 1'b1;
                end
            end
            ST_CALC: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    core_step = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN-1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = fix_res;
                    rd_out_d = rd_pend_q;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= MD_MUL;
            rd_pend_q <= '0;
            rd_out_q  <= '0;
            a_raw_q   <= '0;
            result_q  <= '0;
            neg_q     <= 1'b0;
            sa_q      <= 1'b0;
            div0_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_pend_q <= rd_pend_d;
            rd_out_q  <= rd_out_d;
            a_raw_q   <= a_raw_d;
            result_q  <= result_d;
            neg_q     <= neg_d;
            sa_q      <= sa_d;
            div0_q    <= div0_d;
            ovf_q     <= ovf_d;
        end
    end

    assign stall_o  = accept || (state_q == ST_CALC) || (state_q == ST_FIX);
    assign done_o   = (state_q == ST_DONE);
    assign result_o = result_q;
    assign rd_o     = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv.
module tb_ex_muldiv;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [2:0]  func3_i = 3'b000;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic [4:0]  rd_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int errors = 0;
    int checks = 0;

    ex_muldiv dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .func3_i  (func3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .rd_i     (rd_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o),
        .rd_o     (rd_o)
    );

    always #5 clk_i = ~clk_i;

    // Issues one op in cycle 0 and follows it to done_o (bounded); reports
    // the observed latency, result, tag and whether stall_o held before done_o.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output logic [31:0] res,
                          output logic [4:0] rdo, output logic stall_ok);
        @(negedge clk_i);
        valid_i = 1'b1; func3_i = f; rs1_i = a; rs2_i = b; rd_i = rd;
        #1;
        stall_ok = stall_o;
        lat = -1;
        for (int c = 1; c < 60; c++) begin
            @(negedge clk_i);
            valid_i = 1'b0;
            if (done_o) begin
                lat = c;
                break;
            end
            if (!stall_o) stall_ok = 1'b0;
        end
        res = result_o;
        rdo = rd_o;
        $display("op f=%0d a=%08h b=%08h rd=%0d -> result=%08h rd=%0d latency=%0d",
                 f, a, b, rd, res, rdo, lat);
    endtask

    task automatic test_reset();
        #1;
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall_o); end
        checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL reset_result got=%08h want=00000000", result_o); end
        checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d want=0", rd_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_mul_timing();
        int lat; logic [31:0] res; logic [4:0] rdo; logic sok;
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd9, lat, res, rdo, sok);
        checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency got=%0d want=34", lat); end
        checks++; if (sok !== 1'b1) begin errors++; $display("FAIL mul_stall_window got=%b want=1", sok); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mul_stall_in_done got=%b want=0", stall_o); end
        checks++; if (res !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result got=%08h want=ffffffeb", res); end
        checks++; if (rdo !== 5'd9) begin errors++; $display("FAIL mul_rd got=%0d want=9", rdo); end
        @(negedge clk_i);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL mul_done_pulse got=%b want=0", done_o); end
        checks++; if (result_o !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_result_hold got=%08h want=ffffffeb", result_o); end
    endtask

    task automatic test_vectors();
        logic [2:0]  f_t [13] = '{3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111,
                                  3'b100, 3'b111, 3'b100, 3'b110, 3'b101, 3'b110};
        logic [31:0] a_t [13] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                  32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
                                  32'h8000_0000, 32'h8000_0000, 32'd9, 32'hFFFF_FFF9};
        logic [31:0] b_t [13] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd7,
                                  32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] e_t [13] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                  32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                                  32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
        int lat; logic [31:0] res; logic [4:0] rdo; logic sok;
        for (int i = 0; i < 13; i++) begin
            run_op(f_t[i], a_t[i], b_t[i], 5'(i + 1), lat, res, rdo, sok);
            checks++; if (res !== e_t[i]) begin errors++; $display("FAIL vec%0d_result got=%08h want=%08h", i, res, e_t[i]); end
            checks++; if (lat !== 34) begin errors++; $display("FAIL vec%0d_latency got=%0d want=34", i, lat); end
            checks++; if (rdo !== 5'(i + 1)) begin errors++; $display("FAIL vec%0d_rd got=%0d want=%0d", i, rdo, i + 1); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev; logic seen;
        int lat; logic [31:0] res; logic [4:0] rdo; logic sok;
        @(negedge clk_i);
        prev = result_o;
        valid_i = 1'b1; func3_i = 3'b101; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = 5'd20;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            valid_i = 1'b0;
            if (c == 10) flush_i = 1'b1;
        end
        @(negedge clk_i);
        flush_i = 1'b0;
        $display("flush divu in cycle 10: stall=%b done=%b result=%08h", stall_o, done_o, result_o);
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall got=%b want=0", stall_o); end
        checks++; if (result_o !== prev) begin errors++; $display("FAIL flush_result_kept got=%08h want=%08h", result_o, prev); end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_done got=%b want=0", seen); end
        run_op(3'b000, 32'd3, 32'd4, 5'd21, lat, res, rdo, sok);
        checks++; if (res !== 32'd12) begin errors++; $display("FAIL flush_next_mul got=%08h want=0000000c", res); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL flush_next_latency got=%0d want=34", lat); end
    endtask

    task automatic test_async_reset();
        int lat; logic [31:0] res; logic [4:0] rdo; logic sok;
        @(negedge clk_i);
        valid_i = 1'b1; func3_i = 3'b000; rs1_i = 32'd6; rs2_i = 32'd7; rd_i = 5'd5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            valid_i = 1'b0;
        end
        #2 rst_i = 1'b1;
        #1;
        $display("async reset mid-calc: stall=%b done=%b result=%08h rd=%0d", stall_o, done_o, result_o, rd_o);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL areset_done got=%b want=0", done_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL areset_stall got=%b want=0", stall_o); end
        checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL areset_result got=%08h want=00000000", result_o); end
        checks++; if (rd_o !== 5'd0) begin errors++; $display("FAIL areset_rd got=%0d want=0", rd_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res; logic [4:0] rdo; logic sok;
        run_op(3'b000, 32'd12345, 32'd1000, 5'd7, lat, res, rdo, sok);
        checks++; if (res !== 32'd12345000) begin errors++; $display("FAIL b2b_mul got=%08h want=%08h", res, 32'd12345000); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_mul_latency got=%0d want=34", lat); end
        run_op(3'b101, 32'd1000, 32'd3, 5'd8, lat, res, rdo, sok);
        checks++; if (res !== 32'd333) begin errors++; $display("FAIL b2b_divu got=%08h want=%08h", res, 32'd333); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL b2b_divu_latency got=%0d want=34", lat); end
        checks++; if (rdo !== 5'd8) begin errors++; $display("FAIL b2b_divu_rd got=%0d want=8", rdo); end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_vectors();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
